// File: rtl/iso_pwr_pkg.sv
// Purpose : shared types for the Big1 isolation / power sequencer (state enum, output bundle).
// Latency : n/a (types, constants and a pure decode function only).
// Backpres: n/a.
// Contents: state_e (one-hot), out_t (registered output bundle), per-state decode constants,
//           state_outputs() mapping a state to its output bundle.
package iso_pwr_pkg;

   typedef enum logic [8:0] {
      ON         = 9'h001,
      ISO_ON     = 9'h002,
      SAVE       = 9'h004,
      PSW_OFF    = 9'h008,
      OFF        = 9'h010,
      PSW_ON     = 9'h020,
      RESTORE    = 9'h040,
      ISO_HOLD_S = 9'h080,
      ERR        = 9'h100
   } state_e;

   typedef struct packed {
      logic iso;
      logic pwr_en;
      logic save;
      logic restore;
      logic pwr_on;
      logic busy;
      logic err;
   } out_t;

   //                              iso   pwr_en save  restore pwr_on busy  err
   localparam out_t OUT_ON      = '{1'b0, 1'b1, 1'b0, 1'b0,   1'b1,  1'b0, 1'b0};
   localparam out_t OUT_ISO_ON  = '{1'b1, 1'b1, 1'b0, 1'b0,   1'b0,  1'b1, 1'b0};
   localparam out_t OUT_SAVE    = '{1'b1, 1'b1, 1'b1, 1'b0,   1'b0,  1'b1, 1'b0};
   localparam out_t OUT_PSW_OFF = '{1'b1, 1'b0, 1'b0, 1'b0,   1'b0,  1'b1, 1'b0};
   localparam out_t OUT_OFF     = '{1'b1, 1'b0, 1'b0, 1'b0,   1'b0,  1'b0, 1'b0};
   localparam out_t OUT_PSW_ON  = '{1'b1, 1'b1, 1'b0, 1'b0,   1'b0,  1'b1, 1'b0};
   localparam out_t OUT_RESTORE = '{1'b1, 1'b1, 1'b0, 1'b1,   1'b0,  1'b1, 1'b0};
   localparam out_t OUT_HOLD    = '{1'b1, 1'b1, 1'b0, 1'b0,   1'b0,  1'b1, 1'b0};
   localparam out_t OUT_ERR     = '{1'b1, 1'b0, 1'b0, 1'b0,   1'b0,  1'b0, 1'b1};

   function automatic out_t state_outputs(input state_e s);
      out_t o;
      case (s)
         ON:         o = OUT_ON;
         ISO_ON:     o = OUT_ISO_ON;
         SAVE:       o = OUT_SAVE;
         PSW_OFF:    o = OUT_PSW_OFF;
         OFF:        o = OUT_OFF;
         PSW_ON:     o = OUT_PSW_ON;
         RESTORE:    o = OUT_RESTORE;
         ISO_HOLD_S: o = OUT_HOLD;
         default:    o = OUT_ERR;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/iso_seq_timer.sv
// Purpose : loadable down-counter timing each sequencer phase; done flags the last cycle (cnt==1).
// Latency : value_i visible on the counter the cycle after load_i; done_o is combinational from it.
// Backpres: none; saturates at 0 so untimed states never see a spurious done.
// Ports   : clk, rst (sync, active-high), load_i/value_i (load strobe and value), done_o.
module iso_seq_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] value_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = value_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/iso_pwr_seq_ctrl.sv
// Purpose : power sequencer for Big1: isolate->save->switch off, switch on->restore->release iso.
// Latency : all outputs registered, changing on the same edge as the state; psw_ack has 2-cycle sync.
// Backpres: pwr_req only sampled in ON/OFF; waits on psw_ack with ACK_TMO timeout into sticky ERR.
// Ports   : clk, rst (sync, active-high), pwr_req, psw_ack (async) in;
//           iso, pwr_en, save, restore, pwr_on, busy, err out.
module iso_pwr_seq_ctrl
   import iso_pwr_pkg::*;
#(
   parameter int ISO_SETUP   = 2,
   parameter int SAVE_CYC    = 2,
   parameter int RESTORE_CYC = 2,
   parameter int ISO_HOLD    = 2,
   parameter int ACK_TMO     = 64,
   parameter int CNT_W       = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic pwr_req,
   input  logic psw_ack,
   output logic iso,
   output logic pwr_en,
   output logic save,
   output logic restore,
   output logic pwr_on,
   output logic busy,
   output logic err
);

   localparam logic [CNT_W-1:0] LD_ISO_SETUP   = CNT_W'(ISO_SETUP);
   localparam logic [CNT_W-1:0] LD_SAVE_CYC    = CNT_W'(SAVE_CYC);
   localparam logic [CNT_W-1:0] LD_RESTORE_CYC = CNT_W'(RESTORE_CYC);
   localparam logic [CNT_W-1:0] LD_ISO_HOLD    = CNT_W'(ISO_HOLD);
   localparam logic [CNT_W-1:0] LD_ACK_TMO     = CNT_W'(ACK_TMO);

   logic             ack_meta_q;
   logic             ack_s_q;
   state_e           state_q;
   state_e           state_d;
   out_t             out_q;
   out_t             out_d;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_done;

   iso_seq_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load_i  (tmr_load),
      .value_i (tmr_val),
      .done_o  (tmr_done)
   );

   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         ON: if (!pwr_req) begin
            state_d  = ISO_ON;
            tmr_load = 1'b1;
            tmr_val  = LD_ISO_SETUP;
         end
         ISO_ON: if (tmr_done) begin
            state_d  = SAVE;
            tmr_load = 1'b1;
            tmr_val  = LD_SAVE_CYC;
         end
         SAVE: if (tmr_done) begin
            state_d  = PSW_OFF;
            tmr_load = 1'b1;
            tmr_val  = LD_ACK_TMO;
         end
         // The ack test comes first so an ack landing on the timeout cycle still wins.
         PSW_OFF: begin
            if (!ack_s_q) begin
               state_d = OFF;
            end else if (tmr_done) begin
               state_d = ERR;
            end
         end
         OFF: if (pwr_req) begin
            state_d  = PSW_ON;
            tmr_load = 1'b1;
            tmr_val  = LD_ACK_TMO;
         end
         // After reset the counter is 0, so the post-reset power-up wait is untimed.
         PSW_ON: begin
            if (ack_s_q) begin
               state_d  = RESTORE;
               tmr_load = 1'b1;
               tmr_val  = LD_RESTORE_CYC;
            end else if (tmr_done) begin
               state_d = ERR;
            end
         end
         RESTORE: if (tmr_done) begin
            state_d  = ISO_HOLD_S;
            tmr_load = 1'b1;
            tmr_val  = LD_ISO_HOLD;
         end
         ISO_HOLD_S: if (tmr_done) begin
            state_d = ON;
         end
         ERR:     state_d = ERR;
         default: state_d = ERR;
      endcase

      out_d = state_outputs(state_d);
      // ack_meta_q is what ack_s_q becomes on this edge, so restore never outlives the rail.
      out_d.restore = out_d.restore & ack_meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_meta_q <= 1'b0;
         ack_s_q    <= 1'b0;
         state_q    <= PSW_ON;
         out_q      <= state_outputs(PSW_ON);
      end else begin
         ack_meta_q <= psw_ack;
         ack_s_q    <= ack_meta_q;
         state_q    <= state_d;
         out_q      <= out_d;
      end
   end

   assign iso     = out_q.iso;
   assign pwr_en  = out_q.pwr_en;
   assign save    = out_q.save;
   assign restore = out_q.restore;
   assign pwr_on  = out_q.pwr_on;
   assign busy    = out_q.busy;
   assign err     = out_q.err;

endmodule
